// File: rtl/search_stage_ng_pkg.sv
// Shared definitions for the group-table lookup stage: entry layout and FSM encoding.
// Entry layout, MSB to LSB: {vld, tag, rule_id, next_idx}.
package search_stage_ng_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int NXT_LSB = 0;

    function automatic int ENTRY_WIDTH(input int tag_w, input int index_w);
        return 1 + tag_w + 2 * index_w;
    endfunction

    function automatic int RID_LSB(input int index_w);
        return index_w;
    endfunction

    function automatic int TAG_LSB(input int index_w);
        return 2 * index_w;
    endfunction

    function automatic int VLD_BIT(input int tag_w, input int index_w);
        return 2 * index_w + tag_w;
    endfunction

endpackage

// File: rtl/search_group_table.sv
// One group's rule table: 1R1W synchronous RAM, registered read data held between reads.
module search_group_table #(
    parameter int DEPTH  = 2048,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 60
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/search_stage_ng.sv
// Group-table lookup stage: table clear FSM, update port, two-stage search pipeline.
// Define SEARCH_STAGE_NG_STATS_EN to add saturating lookup/hit counters.
module search_stage_ng
    import search_stage_ng_pkg::*;
#(
    parameter int  NUM_GROUPS = 6,
    parameter int  INDEX_W    = 11,
    parameter int  TAG_W      = 37,
    parameter int  DEPTH      = 2048,
    localparam int ENTRY_W    = ENTRY_WIDTH(TAG_W, INDEX_W),
    localparam int GSEL_W     = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [NUM_GROUPS-1:0]                in_last_match,
    input  logic [NUM_GROUPS-1:0][INDEX_W-1:0]   in_last_rule_id,
    input  logic [NUM_GROUPS-1:0][INDEX_W-1:0]   in_search_index,
    input  logic [NUM_GROUPS-1:0][TAG_W-1:0]     in_search_tag,
    output logic                                 out_valid,
    output logic [NUM_GROUPS-1:0]                out_match,
    output logic [NUM_GROUPS-1:0][INDEX_W-1:0]   out_rule_id,
    output logic [NUM_GROUPS-1:0][INDEX_W-1:0]   out_next_index,
    input  logic                                 upd_valid,
    output logic                                 upd_ready,
    input  logic [GSEL_W-1:0]                    upd_group,
    input  logic [INDEX_W-1:0]                   upd_index,
    input  logic [ENTRY_W-1:0]                   upd_entry,
    output logic                                 init_done
`ifdef SEARCH_STAGE_NG_STATS_EN
    ,
    output logic [31:0]                          stat_lookups,
    output logic [31:0]                          stat_hits
`endif
);

    localparam int VB = VLD_BIT(TAG_W, INDEX_W);
    localparam int TL = TAG_LSB(INDEX_W);
    localparam int RL = RID_LSB(INDEX_W);
    localparam logic [INDEX_W:0] DEPTH_X = (INDEX_W + 1)'(DEPTH);

    state_e                              state_q, state_d;
    logic [INDEX_W-1:0]                  cnt_q, cnt_d;
    logic                                init_done_q;
    logic                                run, accept, upd_ok;
    logic [1:0]                          vld_pipe_q;
    logic [INDEX_W-1:0]                  waddr;
    logic [ENTRY_W-1:0]                  wdata;
    logic [NUM_GROUPS-1:0]               rng, we, re, oob_q, lm_q, hit, evld;
    logic [NUM_GROUPS-1:0][INDEX_W-1:0]  lrid_q;
    logic [NUM_GROUPS-1:0][TAG_W-1:0]    tag_q;
    logic [NUM_GROUPS-1:0][ENTRY_W-1:0]  rd;
    logic [NUM_GROUPS-1:0]               match_q, match_d;
    logic [NUM_GROUPS-1:0][INDEX_W-1:0]  rid_q, rid_d, nxt_q, nxt_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        upd_ready = 1'b0;
        case (state_q)
            ST_INIT: begin
                cnt_d = cnt_q + INDEX_W'(1);
                if (cnt_q == INDEX_W'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                // An update owns the RAM write port this cycle, so search waits.
                in_ready  = !upd_valid;
                upd_ready = 1'b1;
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign run    = (state_q == ST_RUN);
    assign accept = in_valid && in_ready;
    assign upd_ok = run && upd_valid && ({1'b0, upd_index} < DEPTH_X);
    assign waddr  = run ? upd_index : cnt_q;
    assign wdata  = run ? upd_entry : '0;

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_lane
        assign rng[g] = ({1'b0, in_search_index[g]} < DEPTH_X);
        assign re[g]  = accept && rng[g];
        // During INIT every group clears the same address; out-of-range groups never match.
        assign we[g]  = !run || (upd_ok && upd_group == GSEL_W'(g));

        search_group_table #(
            .DEPTH  (DEPTH),
            .ADDR_W (INDEX_W),
            .DATA_W (ENTRY_W)
        ) u_tbl (
            .clk_i   (clk),
            .we_i    (we[g]),
            .waddr_i (waddr),
            .wdata_i (wdata),
            .re_i    (re[g]),
            .raddr_i (in_search_index[g]),
            .rdata_o (rd[g])
        );

        assign evld[g]    = !oob_q[g] && rd[g][VB];
        assign hit[g]     = evld[g] && (rd[g][TL +: TAG_W] == tag_q[g]);
        assign match_d[g] = lm_q[g] | hit[g];
        assign rid_d[g]   = lm_q[g] ? lrid_q[g] : (hit[g] ? rd[g][RL +: INDEX_W] : '0);
        assign nxt_d[g]   = evld[g] ? rd[g][NXT_LSB +: INDEX_W] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            vld_pipe_q  <= '0;
            lm_q        <= '0;
            lrid_q      <= '0;
            tag_q       <= '0;
            oob_q       <= '0;
            match_q     <= '0;
            rid_q       <= '0;
            nxt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= run;
            vld_pipe_q  <= {vld_pipe_q[0], accept};
            if (accept) begin
                lm_q   <= in_last_match;
                lrid_q <= in_last_rule_id;
                tag_q  <= in_search_tag;
                oob_q  <= ~rng;
            end
            if (vld_pipe_q[0]) begin
                match_q <= match_d;
                rid_q   <= rid_d;
                nxt_q   <= nxt_d;
            end
        end
    end

    assign out_valid      = vld_pipe_q[1];
    assign out_match      = match_q;
    assign out_rule_id    = rid_q;
    assign out_next_index = nxt_q;
    assign init_done      = init_done_q;

`ifdef SEARCH_STAGE_NG_STATS_EN
    logic [31:0] lookups_q, hits_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookups_q <= '0;
            hits_q    <= '0;
        end else if (vld_pipe_q[0]) begin
            if (lookups_q != '1)          lookups_q <= lookups_q + 32'd1;
            if ((|hit) && hits_q != '1)   hits_q    <= hits_q + 32'd1;
        end
    end

    assign stat_lookups = lookups_q;
    assign stat_hits    = hits_q;
`endif

endmodule

// File: tb/tb_search_stage_ng.sv
// Randomized bench for search_stage_ng against a table/array reference model.
module tb_search_stage_ng;

    localparam int NG = 6;
    localparam int IW = 11;
    localparam int TW = 37;
    localparam int DP = 2048;
    localparam int EW = 1 + TW + 2 * IW;
    localparam int GW = 3;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   in_valid, in_ready;
    logic [NG-1:0]          in_last_match;
    logic [NG-1:0][IW-1:0]  in_last_rule_id, in_search_index;
    logic [NG-1:0][TW-1:0]  in_search_tag;
    logic                   out_valid;
    logic [NG-1:0]          out_match;
    logic [NG-1:0][IW-1:0]  out_rule_id, out_next_index;
    logic                   upd_valid, upd_ready;
    logic [GW-1:0]          upd_group;
    logic [IW-1:0]          upd_index;
    logic [EW-1:0]          upd_entry;
    logic                   init_done;
`ifdef SEARCH_STAGE_NG_STATS_EN
    logic [31:0]            stat_lookups, stat_hits;
`endif

    always #5 clk = ~clk;

    search_stage_ng #(.NUM_GROUPS(NG), .INDEX_W(IW), .TAG_W(TW), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_last_match(in_last_match), .in_last_rule_id(in_last_rule_id),
        .in_search_index(in_search_index), .in_search_tag(in_search_tag),
        .out_valid(out_valid), .out_match(out_match),
        .out_rule_id(out_rule_id), .out_next_index(out_next_index),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_group(upd_group),
        .upd_index(upd_index), .upd_entry(upd_entry), .init_done(init_done)
`ifdef SEARCH_STAGE_NG_STATS_EN
        , .stat_lookups(stat_lookups), .stat_hits(stat_hits)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: table contents plus the result each accepted beat should produce.
    logic [EW-1:0]          mtbl [NG][DP];
    bit                     s0_v, s0_h, e_v;
    logic [NG-1:0]          s0_m, e_m;
    logic [NG-1:0][IW-1:0]  s0_r, s0_n, e_r, e_n;
    int                     st_look, st_hit;

    task automatic clear_model();
        for (int g = 0; g < NG; g++)
            for (int i = 0; i < DP; i++) mtbl[g][i] = '0;
        s0_v = 0; s0_h = 0; e_v = 0;
        s0_m = '0; s0_r = '0; s0_n = '0;
        e_m = '0; e_r = '0; e_n = '0;
        st_look = 0; st_hit = 0;
    endtask

    task automatic idle();
        in_valid = 0; in_last_match = '0; in_last_rule_id = '0;
        in_search_index = '0; in_search_tag = '0;
        upd_valid = 0; upd_group = '0; upd_index = '0; upd_entry = '0;
    endtask

    function automatic logic [EW-1:0] mk(input bit v, input logic [TW-1:0] t,
                                         input logic [IW-1:0] r, input logic [IW-1:0] n);
        return {v, t, r, n};
    endfunction

    // One RUN-mode cycle: inputs were driven at the preceding negedge.
    task automatic tick();
        bit acc, hit;
        logic [EW-1:0] e;
        #1;
        chk("in_ready", in_ready, !upd_valid);
        chk("upd_ready", upd_ready, 1'b1);
        acc = in_valid && !upd_valid;
        @(posedge clk);
        e_v = s0_v;
        if (s0_v) begin
            e_m = s0_m; e_r = s0_r; e_n = s0_n;
            st_look++;
            if (s0_h) st_hit++;
        end
        s0_v = acc;
        if (acc) begin
            s0_h = 0;
            for (int g = 0; g < NG; g++) begin
                e   = mtbl[g][in_search_index[g]];
                hit = e[EW-1] && (e[EW-2 -: TW] == in_search_tag[g]);
                s0_m[g] = in_last_match[g] | hit;
                s0_r[g] = in_last_match[g] ? in_last_rule_id[g] : (hit ? e[2*IW-1 -: IW] : '0);
                s0_n[g] = e[EW-1] ? e[IW-1:0] : '0;
                if (hit) s0_h = 1;
            end
        end
        if (upd_valid && upd_group < NG) mtbl[upd_group][upd_index] = upd_entry;
        @(negedge clk);
        chk("out_valid", out_valid, e_v);
        chk("out_match", out_match, e_m);
        chk("out_rule_id", out_rule_id, e_r);
        chk("out_next_index", out_next_index, e_n);
    endtask

    task automatic do_reset();
        int n;
        bit done;
        rst = 1;
        idle();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_upd_ready", upd_ready, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_out_match", out_match, 0);
        chk("rst_out_rule_id", out_rule_id, 0);
        chk("rst_out_next_index", out_next_index, 0);
        clear_model();
        in_valid = 1;
        rst = 0;
        n = 0;
        done = 0;
        while (!done && n < DP + 50) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n < DP) chk("init_in_ready", in_ready, 0);
            if (n == DP - 1) in_valid = 0;
            chk("init_out_valid", out_valid, 0);
            done = init_done;
        end
        chk("init_latency", n, DP + 1);
        idle();
    endtask

    task automatic search_g2(input logic [TW-1:0] t, input bit lm, input logic [IW-1:0] lr);
        idle();
        in_valid = 1;
        in_search_index[2] = 11'd5;
        in_search_tag[2]   = t;
        in_last_match[2]   = lm;
        in_last_rule_id[2] = lr;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        idle();
        do_reset();

        // Directed write then hit, carried match, wrong tag.
        upd_valid = 1; upd_group = 3'd2; upd_index = 11'd5;
        upd_entry = mk(1'b1, 37'h1234, 11'd77, 11'd9);
        tick();
        search_g2(37'h1234, 1'b0, 11'd0); tick();
        idle(); tick();
        chk("dir_match", out_match[2], 1);
        chk("dir_rid", out_rule_id[2], 77);
        chk("dir_nxt", out_next_index[2], 9);
        search_g2(37'h1234, 1'b1, 11'd3); tick();
        idle(); tick();
        chk("carry_rid", out_rule_id[2], 3);
        chk("carry_nxt", out_next_index[2], 9);
        search_g2(37'h1235, 1'b0, 11'd0); tick();
        idle(); tick();
        chk("miss_match", out_match[2], 0);
        chk("miss_rid", out_rule_id[2], 0);

        // Search held while a write to the same entry slips in between two lookups.
        search_g2(37'h1234, 1'b0, 11'd0); tick();
        upd_valid = 1; upd_group = 3'd2; upd_index = 11'd5;
        upd_entry = mk(1'b1, 37'h1234, 11'd100, 11'd12);
        tick();
        chk("order_old_rid", out_rule_id[2], 77);
        upd_valid = 0; tick();
        idle(); tick();
        chk("order_new_rid", out_rule_id[2], 100);
        chk("order_new_nxt", out_next_index[2], 12);

        // Randomized traffic on a small index/tag space so hits and overwrites are common.
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            upd_valid = ($urandom_range(0, 3) == 0);
            upd_group = GW'($urandom_range(0, 7));
            upd_index = IW'($urandom_range(0, 7));
            upd_entry = mk(($urandom_range(0, 3) != 0), TW'($urandom_range(0, 3)),
                           IW'($urandom), IW'($urandom));
            for (int g = 0; g < NG; g++) begin
                in_search_index[g] = IW'($urandom_range(0, 7));
                in_search_tag[g]   = TW'($urandom_range(0, 3));
                in_last_match[g]   = ($urandom_range(0, 3) == 0);
                in_last_rule_id[g] = IW'($urandom);
            end
            tick();
        end
        idle(); tick(); tick();

`ifdef SEARCH_STAGE_NG_STATS_EN
        chk("stat_lookups", stat_lookups, st_look);
        chk("stat_hits", stat_hits, st_hit);
`endif

        // Reset with a beat in flight: it must never surface, and the table must be cleared.
        search_g2(37'h1234, 1'b0, 11'd0);
        upd_valid = 1; upd_group = 3'd2; upd_index = 11'd5;
        upd_entry = mk(1'b1, 37'h1234, 11'd55, 11'd7);
        tick();
        upd_valid = 0;
        @(posedge clk);
        #1 rst = 1;
        chk("midrst_out_valid", out_valid, 0);
        do_reset();
        search_g2(37'h1234, 1'b0, 11'd0); tick();
        idle(); tick();
        chk("reinit_match", out_match[2], 0);
        chk("reinit_nxt", out_next_index[2], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
